// File: rtl/hazard_bubble_ctrl_pkg.sv
// Shared opcode header for the issue stage: RV32I opcodes, the NOP encoding,
// the scoreboard entry type and operand-usage decode helpers.
package hazard_bubble_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

    function automatic logic writes_rd(input logic [6:0] opc);
        return !(opc == OPC_BRANCH || opc == OPC_STORE);
    endfunction

    function automatic logic uses_rs1(input logic [6:0] opc);
        return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return opc == OPC_OP || opc == OPC_BRANCH || opc == OPC_STORE;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Destination-register history of the last DEPTH issue slots (entry 0 youngest),
// with the JALR rs1 any-match and the entry-0 load-use compare.
module hazard_scoreboard
    import hazard_bubble_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      shift_en,
    input  sb_entry_t new_entry,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic      use_rs1,
    input  logic      use_rs2,
    output logic      rs1_match,
    output logic      load_use
);

    sb_entry_t sb_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sb_q[i] <= '0;
            end
        end else if (shift_en) begin
            sb_q[0] <= new_entry;
            for (int i = 1; i < DEPTH; i++) begin
                sb_q[i] <= sb_q[i-1];
            end
        end
    end

    always_comb begin
        rs1_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sb_q[i].v && sb_q[i].rd == rs1) begin
                rs1_match = 1'b1;
            end
        end
        if (rs1 == 5'd0) begin
            rs1_match = 1'b0;
        end
    end

    always_comb begin
        load_use = 1'b0;
        if (sb_q[0].v && sb_q[0].is_load) begin
            if (use_rs1 && rs1 != 5'd0 && sb_q[0].rd == rs1) begin
                load_use = 1'b1;
            end
            if (use_rs2 && rs2 != 5'd0 && sb_q[0].rd == rs2) begin
                load_use = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_bubble_ctrl.sv
// Issue-stage bubble controller: picks the fetched instruction or a NOP each cycle
// from stall, control-flow penalty and scoreboard hazards, and counts bubbles.
module hazard_bubble_ctrl
    import hazard_bubble_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH          = 2,
    parameter int unsigned BRANCH_PENALTY = 1,
    parameter int unsigned JUMP_PENALTY   = 0,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      icache_dout,
    input  logic             stall,
    output logic             nop_sel,
    output logic             hold_pc,
    output logic [31:0]      issued_inst,
    output logic [CNT_W-1:0] bubble_count
);

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic       is_branch, is_jump, is_jalr;
    logic       rs1_match, load_use;
    logic [2:0] pc_cnt_q, pc_cnt_d;
    sb_entry_t  new_entry;

    assign opcode    = icache_dout[6:0];
    assign rd        = icache_dout[11:7];
    assign rs1       = icache_dout[19:15];
    assign rs2       = icache_dout[24:20];
    assign is_branch = opcode == OPC_BRANCH;
    assign is_jalr   = opcode == OPC_JALR;
    assign is_jump   = is_jalr || opcode == OPC_JAL;

    always_comb begin
        nop_sel = 1'b0;
        hold_pc = 1'b0;
        if (stall) begin
            nop_sel = 1'b1;
            hold_pc = 1'b1;
        end else if (pc_cnt_q != 3'd0) begin
            nop_sel = 1'b1;
        end else if (is_jalr && rs1_match) begin
            nop_sel = 1'b1;
            hold_pc = 1'b1;
        end else if (load_use) begin
            nop_sel = 1'b1;
            hold_pc = 1'b1;
        end
    end

    assign issued_inst = nop_sel ? INST_NOP : icache_dout;

    // Bubbles enter the scoreboard as invalid so a retried JALR drains out.
    always_comb begin
        new_entry.v       = writes_rd(opcode) && !nop_sel && rd != 5'd0;
        new_entry.rd      = rd;
        new_entry.is_load = opcode == OPC_LOAD;
    end

    hazard_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (!stall),
        .new_entry (new_entry),
        .rs1       (rs1),
        .rs2       (rs2),
        .use_rs1   (uses_rs1(opcode)),
        .use_rs2   (uses_rs2(opcode)),
        .rs1_match (rs1_match),
        .load_use  (load_use)
    );

    always_comb begin
        pc_cnt_d = pc_cnt_q;
        if (!stall) begin
            if (!nop_sel && is_branch) begin
                pc_cnt_d = 3'(BRANCH_PENALTY);
            end else if (!nop_sel && is_jump) begin
                pc_cnt_d = 3'(JUMP_PENALTY);
            end else if (pc_cnt_q != 3'd0) begin
                pc_cnt_d = pc_cnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_cnt_q     <= 3'd0;
            bubble_count <= '0;
        end else begin
            pc_cnt_q <= pc_cnt_d;
            if (!stall && nop_sel && bubble_count != '1) begin
                bubble_count <= bubble_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/hazard_bubble_ctrl.md
# hazard_bubble_ctrl

Issue-stage bubble controller for the pipelined RISC-V core, and the parametrised successor of the single-cycle NOP selector. It chooses, every cycle, between the fetched instruction and a NOP. Decisions draw on four sources: an external stall, a multi-cycle control-flow penalty counter, a DEPTH-entry destination-register scoreboard (JALR rs1 hazards), and load-use detection. It also tells PC logic whether to re-present the same instruction, and it counts inserted bubbles for performance monitoring.

## Interface
- DEPTH, 2: in-flight instructions tracked by the scoreboard (1..4)
- BRANCH_PENALTY, 1: NOP cycles inserted after an issued BRANCH (0..7)
- JUMP_PENALTY, 0: NOP cycles inserted after an issued JAL/JALR (0..7)
- CNT_W, 16: width of the bubble counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- icache_dout  in  32  fetched instruction
- stall  in  1  external pipeline freeze (memory wait)
- nop_sel  out  1  1 = issue NOP, 0 = issue icache_dout
- hold_pc  out  1  1 = PC must re-present the same instruction next cycle
- issued_inst  out  32  icache_dout, or INST_NOP (32'h0000_0013) when nop_sel=1
- bubble_count  out  CNT_W  saturating count of NOPs inserted while not stalled

## Operation
- Decode of icache_dout: opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20].
- rd-writing opcodes: all except BRANCH and STORE. rs2 is used by OP, BRANCH and STORE.
- Scoreboard: DEPTH entries {v, rd, is_load}. Entry 0 is the youngest.
- The scoreboard shifts on every non-stalled cycle:
  - New entry 0 = {rd-writing & ~nop_sel & rd≠0, rd, opcode==LOAD}.
  - A NOP enters with v=0.
- Penalty counter pc_cnt (3 bits):
  - Loads BRANCH_PENALTY or JUMP_PENALTY when a BRANCH or JAL/JALR issues (nop_sel=0, stall=0).
  - Otherwise decrements toward 0 on each non-stalled cycle.
- Decision priority, highest first:
  - stall: nop_sel=1, hold_pc=1; scoreboard, pc_cnt and bubble_count frozen.
  - pc_cnt≠0: nop_sel=1, hold_pc=0 (wrong-path fetch discarded).
  - JALR hazard: the current instruction is JALR, rs1≠0, and rs1 matches any valid entry. Result: nop_sel=1, hold_pc=1.
  - Load-use: entry 0 is valid with is_load=1, and its rd equals a used rs1 or rs2 (≠0). Result: nop_sel=1, hold_pc=1.
  - else: nop_sel=0, hold_pc=0.
- A hazard NOP shifts an invalid entry in, so a retried JALR clears after at most DEPTH bubbles.
- bubble_count increments when nop_sel=1 and stall=0, and saturates at all-ones.

## Timing
- nop_sel, hold_pc and issued_inst are combinational from icache_dout, stall and registered state. They resolve in the same cycle, with no latency.
- Scoreboard, pc_cnt and bubble_count update at the clock edge that follows the decision.
- Reset values: all scoreboard v=0, pc_cnt=0, bubble_count=0.
- First cycle after reset: nop_sel = stall, issued_inst follows from it.
- Penalty NOPs follow the branch with no gap: a BRANCH issued at cycle t yields NOPs at t+1..t+BRANCH_PENALTY.
- With a penalty of 0, the counter never loads.
- Stall during a penalty extends it: the count does not decrement while stalled.
- Reset asserted mid-penalty or mid-hazard wins: state clears at that edge.
- A BRANCH issued when its penalty parameter is 0 and the next instruction is a hazard: the hazard is evaluated normally.

## Structure
- The shared opcode header holds the OPC_* codes. Add INST_NOP and a macro for the rd-writing opcode set there.
- One sub-module, hazard_scoreboard, contains:
  - the DEPTH-entry shift register;
  - the rs1 any-match and entry-0 load-use compare.
- Top level holds pc_cnt, bubble_count and the priority mux.

## Test plan
- Reset: assert rst 2 cycles with stall=0 and icache_dout=ADDI x1,x0,1 → nop_sel=0, bubble_count=0, issued_inst=ADDI.
- BRANCH_PENALTY=2: issue BEQ, then ADDI for 3 cycles → nop_sel 1,1,0 with hold_pc=0, and bubble_count=2.
- DEPTH=2: issue ADDI x5, then ADDI x6, then JALR x0,0(x5) → JALR held for 1 bubble (hold_pc=1), then issues; with rd=x0 there is no bubble.
- Load-use: LW x3 then ADD x4,x3,x2 → exactly 1 NOP with hold_pc=1, then ADD issues. The same pair with rs=x0 gives no NOP.
- Stall: stall=1 for 3 cycles while pc_cnt=1 → nop_sel=1 and hold_pc=1 throughout, bubble_count unchanged, then 1 penalty NOP after release.
- Saturation, CNT_W=4: 20 penalty NOPs → bubble_count stays at 15.
